// File: rtl/amo_pkg.sv
// -----------------------------------------------------------------------------
// amo_pkg
// Shared types and constants for the data-side memory controller.
//   amo_op_e         : atomic operation selector (AMO_NONE for plain accesses)
//   amo_ctrl_state_e : controller sequencing states
//   AMO_FULL_MASK    : byte mask used for every atomic memory access
// -----------------------------------------------------------------------------
package amo_pkg;

   typedef enum logic [3:0] {
      AMO_NONE = 4'd0,
      LR       = 4'd1,
      SC       = 4'd2,
      SWAP     = 4'd3,
      ADD      = 4'd4,
      XOR      = 4'd5,
      AND      = 4'd6,
      OR       = 4'd7,
      MIN      = 4'd8,
      MAX      = 4'd9,
      MINU     = 4'd10,
      MAXU     = 4'd11
   } amo_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RSP  = 2'd3
   } amo_ctrl_state_e;

   localparam logic [3:0] AMO_FULL_MASK = 4'b1111;

endpackage

// File: rtl/amo_alu.sv
// -----------------------------------------------------------------------------
// amo_alu
// Combinational read-modify-write function for RV32A atomics.
// Ports:
//   op      : atomic operation
//   old_val : value read from memory
//   operand : rs2 / store data
//   result  : value to write back (operand for SWAP and for non-RMW ops)
// -----------------------------------------------------------------------------
module amo_alu
   import amo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  amo_op_e                 op,
   input  logic [DATA_WIDTH-1:0]   old_val,
   input  logic [DATA_WIDTH-1:0]   operand,
   output logic [DATA_WIDTH-1:0]   result
);

   // Signed compares for MIN/MAX, unsigned for MINU/MAXU; ADD wraps naturally
   // at DATA_WIDTH bits.
   always_comb begin
      result = operand;
      case (op)
         ADD:     result = old_val + operand;
         XOR:     result = old_val ^ operand;
         AND:     result = old_val & operand;
         OR:      result = old_val | operand;
         MIN:     result = ($signed(old_val) < $signed(operand)) ? old_val : operand;
         MAX:     result = ($signed(old_val) > $signed(operand)) ? old_val : operand;
         MINU:    result = (old_val < operand) ? old_val : operand;
         MAXU:    result = (old_val > operand) ? old_val : operand;
         default: result = operand;
      endcase
   end

endmodule

// File: rtl/amo_mem_ctrl.sv
// -----------------------------------------------------------------------------
// amo_mem_ctrl
// Data-side memory controller between the core data port and unified memory.
// Forwards plain loads/stores, runs AMOs as a locked read-modify-write and
// implements LR.W/SC.W with a single-entry reservation.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   core_req_*              : request handshake, kind (re/we/amo), addr, data, mask
//   core_resp_*             : one-cycle response strobe, read data, misalign error
//   mem_re/mem_we           : memory read/write enables (never both high)
//   mem_mask/addr/wdata     : registered memory command, stable during RD/WR
//   mem_rdata/mem_read_resp : memory read data and its valid flag
// -----------------------------------------------------------------------------
module amo_mem_ctrl
   import amo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    core_req_valid,
   output logic                    core_req_ready,
   input  logic                    core_req_re,
   input  logic                    core_req_we,
   input  amo_op_e                 core_req_amo,
   input  logic [ADDR_WIDTH-1:0]   core_req_addr,
   input  logic [DATA_WIDTH-1:0]   core_req_wdata,
   input  logic [3:0]              core_req_mask,
   output logic                    core_resp_valid,
   output logic [DATA_WIDTH-1:0]   core_resp_rdata,
   output logic                    core_resp_err,
   output logic                    mem_re,
   output logic                    mem_we,
   output logic [3:0]              mem_mask,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_read_resp
);

   amo_ctrl_state_e         state_q, state_d;
   amo_op_e                 op_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;

   logic                    resv_valid_q, resv_valid_d;
   logic [ADDR_WIDTH-3:0]   resv_addr_q, resv_addr_d;

   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;

   logic                    mem_re_q, mem_re_d;
   logic                    mem_we_q, mem_we_d;
   logic [3:0]              mem_mask_q, mem_mask_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

   logic                    req_fire;
   logic                    req_is_amo;
   logic [1:0]              req_kinds;
   logic                    req_resv_hit;
   logic                    wr_resv_hit;
   logic [DATA_WIDTH-1:0]   alu_result;

   assign core_req_ready = (state_q == IDLE) && !rst;
   assign req_fire       = core_req_valid && core_req_ready;
   assign req_is_amo     = (core_req_amo != AMO_NONE);
   assign req_kinds      = {1'b0, core_req_re} + {1'b0, core_req_we} + {1'b0, req_is_amo};
   assign req_resv_hit   = resv_valid_q && (core_req_addr[ADDR_WIDTH-1:2] == resv_addr_q);
   assign wr_resv_hit    = resv_valid_q && (addr_q[ADDR_WIDTH-1:2] == resv_addr_q);

   // Outputs are forced low while reset is held, so nothing leaks out in the
   // cycle where reset is first seen but the registers have not yet cleared.
   assign core_resp_valid = (state_q == RSP) && !rst;
   assign core_resp_rdata = core_resp_valid ? rsp_rdata_q : '0;
   assign core_resp_err   = core_resp_valid && rsp_err_q;
   assign mem_re          = mem_re_q && !rst;
   assign mem_we          = mem_we_q && !rst && !mem_re_q;
   assign mem_mask        = rst ? 4'b0 : mem_mask_q;
   assign mem_addr        = rst ? '0 : mem_addr_q;
   assign mem_wdata       = rst ? '0 : mem_wdata_q;

   // The ALU works on the word arriving from memory so the AMO write data is
   // ready to register on the same edge that leaves RD.
   amo_alu #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_alu (
      .op      (op_q),
      .old_val (mem_rdata),
      .operand (wdata_q),
      .result  (alu_result)
   );

   // Next-state and next-command logic. Memory command registers default to
   // zero so they read as 0 in IDLE/RSP, and are only loaded when the next
   // state is RD or WR (or held while RD waits on memory).
   always_comb begin
      state_d      = state_q;
      resv_valid_d = resv_valid_q;
      resv_addr_d  = resv_addr_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_mask_d   = 4'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;

      case (state_q)
         IDLE: begin
            if (req_fire) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               if (req_kinds != 2'd1) begin
                  state_d = RSP;
               end else if (req_is_amo && (core_req_addr[1:0] != 2'b00)) begin
                  state_d   = RSP;
                  rsp_err_d = 1'b1;
               end else if (core_req_re || (req_is_amo && core_req_amo != SC)) begin
                  state_d    = RD;
                  mem_re_d   = 1'b1;
                  mem_addr_d = core_req_addr;
                  mem_mask_d = core_req_re ? core_req_mask : AMO_FULL_MASK;
               end else if (core_req_we) begin
                  state_d     = WR;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = core_req_addr;
                  mem_mask_d  = core_req_mask;
                  mem_wdata_d = core_req_wdata;
               end else begin
                  // SC: the reservation is consumed whether or not it succeeds.
                  resv_valid_d = 1'b0;
                  if (req_resv_hit) begin
                     state_d     = WR;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = core_req_addr;
                     mem_mask_d  = AMO_FULL_MASK;
                     mem_wdata_d = core_req_wdata;
                  end else begin
                     state_d     = RSP;
                     rsp_rdata_d = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                  end
               end
            end
         end

         RD: begin
            if (mem_read_resp) begin
               rsp_rdata_d = mem_rdata;
               if (op_q == AMO_NONE || op_q == LR) begin
                  state_d = RSP;
                  if (op_q == LR) begin
                     resv_valid_d = 1'b1;
                     resv_addr_d  = addr_q[ADDR_WIDTH-1:2];
                  end
               end else begin
                  state_d     = WR;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr_q;
                  mem_mask_d  = AMO_FULL_MASK;
                  mem_wdata_d = alu_result;
               end
            end else begin
               mem_re_d   = 1'b1;
               mem_addr_d = mem_addr_q;
               mem_mask_d = mem_mask_q;
            end
         end

         WR: begin
            state_d = RSP;
            if (wr_resv_hit) begin
               resv_valid_d = 1'b0;
            end
         end

         RSP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencing state, reservation, response and memory command registers.
   // Reset aborts any sequence in flight, dropping a pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         resv_valid_q <= 1'b0;
         resv_addr_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_mask_q   <= 4'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         resv_valid_q <= resv_valid_d;
         resv_addr_q  <= resv_addr_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_mask_q   <= mem_mask_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Request fields are captured on acceptance and reused by the RD->WR step
   // of an AMO.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= AMO_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (req_fire) begin
         op_q    <= core_req_amo;
         addr_q  <= core_req_addr;
         wdata_q <= core_req_wdata;
      end
   end

endmodule

// File: tb/tb_amo_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_amo_mem_ctrl
// Scoreboard bench for amo_mem_ctrl: a behavioural memory answers the DUT's
// memory port, a reference model predicts each response, and a monitor pops
// and compares whenever the DUT strobes core_resp_valid.
// -----------------------------------------------------------------------------
module tb_amo_mem_ctrl;
   import amo_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_req_valid;
   logic          core_req_ready;
   logic          core_req_re;
   logic          core_req_we;
   amo_op_e       core_req_amo;
   logic [31:0]   core_req_addr;
   logic [31:0]   core_req_wdata;
   logic [3:0]    core_req_mask;
   logic          core_resp_valid;
   logic [31:0]   core_resp_rdata;
   logic          core_resp_err;
   logic          mem_re;
   logic          mem_we;
   logic [3:0]    mem_mask;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_read_resp;

   amo_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .core_req_valid  (core_req_valid),
      .core_req_ready  (core_req_ready),
      .core_req_re     (core_req_re),
      .core_req_we     (core_req_we),
      .core_req_amo    (core_req_amo),
      .core_req_addr   (core_req_addr),
      .core_req_wdata  (core_req_wdata),
      .core_req_mask   (core_req_mask),
      .core_resp_valid (core_resp_valid),
      .core_resp_rdata (core_resp_rdata),
      .core_resp_err   (core_resp_err),
      .mem_re          (mem_re),
      .mem_we          (mem_we),
      .mem_mask        (mem_mask),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_read_resp   (mem_read_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          re_n;
      int          we_n;
      int          lat;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [31:0]   dmem [int];
   logic [31:0]   ref_mem [int];
   bit            ref_resv_v = 0;
   int            ref_resv_w = 0;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   int            lat_override = -1;
   int            wait_cnt = 0;
   int            mon_re = 0;
   int            mon_we = 0;
   int            mon_both = 0;
   int            mw;
   logic [31:0]   mword;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dut_word(int w);
      return dmem.exists(w) ? dmem[w] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_word(int w);
      return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      dmem[int'(addr >> 2)]    = val;
      ref_mem[int'(addr >> 2)] = val;
   endtask

   // Behavioural memory: answers reads after a random wait, applies masked
   // writes when mem_we is seen.
   always @(negedge clk) begin
      if (mem_we) begin
         mw    = int'(mem_addr >> 2);
         mword = dut_word(mw);
         for (int b = 0; b < 4; b++)
            if (mem_mask[b]) mword[8*b +: 8] = mem_wdata[8*b +: 8];
         dmem[mw] = mword;
      end
      if (mem_re) begin
         if (wait_cnt == 0) begin
            mem_read_resp = 1'b1;
            mem_rdata     = dut_word(int'(mem_addr >> 2));
         end else begin
            wait_cnt--;
            mem_read_resp = 1'b0;
            mem_rdata     = $urandom;
         end
      end else begin
         mem_read_resp = 1'b0;
         wait_cnt      = (lat_override >= 0) ? lat_override : int'($urandom_range(0, 3));
      end
   end

   // Monitor: accumulates memory activity per transaction and checks each
   // response against the head of the scoreboard queue.
   always @(negedge clk) begin
      if (rst) begin
         mon_re   = 0;
         mon_we   = 0;
         mon_both = 0;
      end else begin
         if (mem_re) mon_re++;
         if (mem_we) mon_we++;
         if (mem_re && mem_we) mon_both++;
         if (core_resp_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_resp: got rdata 0x%08h with no request pending", core_resp_rdata);
            end else begin
               mon_e = exp_q.pop_front();
               check_output("resp_rdata", core_resp_rdata, mon_e.rdata);
               check_output("resp_err", 32'(core_resp_err), 32'(mon_e.err));
               check_output("mem_read_seen", 32'(mon_re != 0), 32'(mon_e.re_n));
               check_output("mem_write_cycles", 32'(mon_we), 32'(mon_e.we_n));
               check_output("re_we_overlap", 32'(mon_both), 32'd0);
               if (mon_e.lat >= 0)
                  check_output("resp_latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
            end
            mon_re   = 0;
            mon_we   = 0;
            mon_both = 0;
         end
      end
   end

   // Reference model: derives the response and memory effect of a request
   // directly from the architectural rules.
   task automatic ref_issue(input logic re, input logic we, input amo_op_e op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask);
      exp_t        e;
      int          w;
      int          kinds;
      logic [31:0] old, nv;
      w      = int'(addr >> 2);
      kinds  = int'(re) + int'(we) + int'(op != AMO_NONE);
      e.rdata = 32'h0;
      e.err   = 1'b0;
      e.re_n  = 0;
      e.we_n  = 0;
      e.lat   = -1;
      old     = ref_word(w);
      if (kinds != 1) begin
      end else if (op != AMO_NONE && addr[1:0] != 2'b00) begin
         e.err = 1'b1;
      end else if (re) begin
         e.rdata = old;
         e.re_n  = 1;
      end else if (we) begin
         nv = old;
         for (int b = 0; b < 4; b++)
            if (mask[b]) nv[8*b +: 8] = wdata[8*b +: 8];
         ref_mem[w] = nv;
         if (ref_resv_v && ref_resv_w == w) ref_resv_v = 0;
         e.we_n = 1;
         e.lat  = 2;
      end else if (op == LR) begin
         e.rdata    = old;
         e.re_n     = 1;
         ref_resv_v = 1;
         ref_resv_w = w;
      end else if (op == SC) begin
         if (ref_resv_v && ref_resv_w == w) begin
            ref_mem[w] = wdata;
            e.we_n     = 1;
         end else begin
            e.rdata = 32'd1;
         end
         ref_resv_v = 0;
      end else begin
         case (op)
            SWAP:    nv = wdata;
            ADD:     nv = 32'((longint'(old) + longint'(wdata)) % 64'h1_0000_0000);
            XOR:     nv = old ^ wdata;
            AND:     nv = old & wdata;
            OR:      nv = old | wdata;
            MIN:     nv = (int'(old) <= int'(wdata)) ? old : wdata;
            MAX:     nv = (int'(old) >= int'(wdata)) ? old : wdata;
            MINU:    nv = (old <= wdata) ? old : wdata;
            MAXU:    nv = (old >= wdata) ? old : wdata;
            default: nv = wdata;
         endcase
         ref_mem[w] = nv;
         if (ref_resv_v && ref_resv_w == w) ref_resv_v = 0;
         e.rdata = old;
         e.re_n  = 1;
         e.we_n  = 1;
      end
      exp_q.push_back(e);
   endtask

   task automatic drive_idle();
      core_req_valid = 1'b0;
      core_req_re    = 1'b0;
      core_req_we    = 1'b0;
      core_req_amo   = AMO_NONE;
      core_req_addr  = 32'h0;
      core_req_wdata = 32'h0;
      core_req_mask  = 4'h0;
   endtask

   // Waits (bounded) for ready, presents the request for one accepting edge.
   task automatic apply_stimulus(input logic re, input logic we, input amo_op_e op,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input bit expect_resp);
      int n;
      n = 0;
      @(negedge clk);
      while (!core_req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!core_req_ready) begin
         check_output("ready_timeout", 32'(core_req_ready), 32'd1);
         return;
      end
      if (expect_resp) ref_issue(re, we, op, addr, wdata, mask);
      core_req_valid = 1'b1;
      core_req_re    = re;
      core_req_we    = we;
      core_req_amo   = op;
      core_req_addr  = addr;
      core_req_wdata = wdata;
      core_req_mask  = mask;
      @(posedge clk);
      #1;
      acc_cyc = cyc - 1;
      drive_idle();
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      logic        r_re, r_we;
      amo_op_e     r_op;
      logic [31:0] r_addr;
      int          kind;

      drive_idle();
      rst           = 1'b1;
      mem_rdata     = 32'h0;
      mem_read_resp = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_outputs_zero",
                   32'({core_req_ready, core_resp_valid, mem_re, mem_we}) | mem_addr | mem_wdata | 32'(mem_mask),
                   32'h0);
      rst = 1'b0;
      @(negedge clk);
      check_output("ready_after_reset", 32'(core_req_ready), 32'd1);

      // Store then load back; store carries the two-cycle latency check.
      apply_stimulus(0, 1, AMO_NONE, 32'h100, 32'hDEADBEEF, 4'hF, 1);
      apply_stimulus(1, 0, AMO_NONE, 32'h100, 32'h0, 4'hF, 1);
      wait_drain();
      check_output("load_store_mem", dut_word(32'h100 >> 2), 32'hDEADBEEF);

      // AMOADD across the signed overflow boundary.
      preload(32'h200, 32'h7FFFFFFF);
      apply_stimulus(0, 0, ADD, 32'h200, 32'h1, 4'h0, 1);
      wait_drain();
      check_output("amoadd_mem", dut_word(32'h200 >> 2), 32'h80000000);

      // Signed vs unsigned minimum against all-ones.
      preload(32'h204, 32'hFFFFFFFF);
      apply_stimulus(0, 0, MIN, 32'h204, 32'h1, 4'h0, 1);
      wait_drain();
      check_output("amomin_mem", dut_word(32'h204 >> 2), 32'hFFFFFFFF);
      apply_stimulus(0, 0, MINU, 32'h204, 32'h1, 4'h0, 1);
      wait_drain();
      check_output("amominu_mem", dut_word(32'h204 >> 2), 32'h00000001);

      // LR/SC success, then a second SC that must fail.
      apply_stimulus(0, 0, LR, 32'h300, 32'h0, 4'h0, 1);
      apply_stimulus(0, 0, SC, 32'h300, 32'h5, 4'h0, 1);
      wait_drain();
      check_output("sc_success_mem", dut_word(32'h300 >> 2), 32'h5);
      apply_stimulus(0, 0, SC, 32'h300, 32'h9, 4'h0, 1);
      wait_drain();
      check_output("sc_fail_mem", dut_word(32'h300 >> 2), 32'h5);

      // Plain store breaks the reservation; SC to a different word fails.
      apply_stimulus(0, 0, LR, 32'h300, 32'h0, 4'h0, 1);
      apply_stimulus(0, 1, AMO_NONE, 32'h300, 32'h77, 4'h1, 1);
      apply_stimulus(0, 0, SC, 32'h300, 32'h1234, 4'h0, 1);
      apply_stimulus(0, 0, LR, 32'h300, 32'h0, 4'h0, 1);
      apply_stimulus(0, 0, SC, 32'h304, 32'h4321, 4'h0, 1);

      // Misaligned atomic, malformed request, partial-mask store.
      apply_stimulus(0, 0, SWAP, 32'h102, 32'hCAFEF00D, 4'h0, 1);
      apply_stimulus(1, 1, AMO_NONE, 32'h100, 32'h1, 4'hF, 1);
      apply_stimulus(0, 0, AMO_NONE, 32'h100, 32'h1, 4'hF, 1);
      apply_stimulus(0, 1, AMO_NONE, 32'h100, 32'hA5A5A5A5, 4'b0101, 1);
      wait_drain();
      check_output("partial_mask_mem", dut_word(32'h100 >> 2), 32'hDEA5BEA5);

      // Randomised traffic over a few words so reservations and RMWs collide.
      for (int i = 0; i < 150; i++) begin
         kind   = int'($urandom_range(0, 15));
         r_re   = 1'b0;
         r_we   = 1'b0;
         r_op   = AMO_NONE;
         r_addr = 32'h400 + 32'($urandom_range(0, 3)) * 4;
         if ($urandom_range(0, 7) == 0) r_addr = r_addr + 32'($urandom_range(1, 3));
         if (kind < 2)       r_re = 1'b1;
         else if (kind < 4)  r_we = 1'b1;
         else if (kind == 4) begin
            r_re = 1'b1;
            r_op = amo_op_e'($urandom_range(1, 11));
         end else            r_op = amo_op_e'($urandom_range(1, 11));
         apply_stimulus(r_re, r_we, r_op, r_addr, $urandom, 4'($urandom_range(0, 15)), 1);
      end
      wait_drain();

      // Reset in the middle of an AMOADD read: the write must be dropped,
      // no response issued, and the reservation lost.
      apply_stimulus(0, 0, LR, 32'h300, 32'h0, 4'h0, 1);
      wait_drain();
      preload(32'h200, 32'h11111111);
      lat_override = 6;
      apply_stimulus(0, 0, ADD, 32'h200, 32'h22222222, 4'h0, 0);
      n = 0;
      while (!mem_re && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output("amo_rd_started", 32'(mem_re), 32'd1);
      rst = 1'b1;
      #1;
      check_output("abort_outputs_zero",
                   32'({core_req_ready, core_resp_valid, mem_re, mem_we}), 32'h0);
      repeat (2) @(negedge clk);
      rst          = 1'b0;
      ref_resv_v   = 0;
      lat_override = -1;
      @(negedge clk);
      check_output("ready_after_abort", 32'(core_req_ready), 32'd1);
      repeat (4) @(negedge clk);
      check_output("abort_mem_unchanged", dut_word(32'h200 >> 2), 32'h11111111);
      apply_stimulus(0, 0, SC, 32'h300, 32'hBEEF, 4'h0, 1);
      wait_drain();

      // Final memory image must match the reference.
      foreach (ref_mem[k])
         check_output($sformatf("mem_word_%0h", k * 4), dut_word(k), ref_mem[k]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
